// File: rtl/imem_loader_if.sv
// Bundles the boot byte stream, start/length control, status flags and the
// instruction-memory write port. The checksum member exists only with IMEM_LOADER_CHECKSUM_EN.
interface imem_loader_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] length;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic             busy;
  logic             done;
  logic             error;
  logic             cpu_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       checksum;

  modport slave (
    input  start, length, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, wr_strb, busy, done, error, cpu_hold, checksum
  );
  modport master (
    output start, length, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, wr_strb, busy, done, error, cpu_hold, checksum
  );
`else
  modport slave (
    input  start, length, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, wr_strb, busy, done, error, cpu_hold
  );
  modport master (
    output start, length, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, wr_strb, busy, done, error, cpu_hold
  );
`endif
endinterface

// File: rtl/imem_loader.sv
// Packs a boot byte stream into little-endian 32-bit words written to instruction memory
// from BASE_ADDR, holding the CPU while loading. Optional byte checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          DEPTH_WORDS = 25,
  parameter int          LEN_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  localparam int          WIDX_W    = $clog2(DEPTH_WORDS + 1);
  localparam logic [32:0] CAP_BYTES = 33'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;
  logic [3:0][7:0]   pack_q, pack_d, pack_merged;
  logic [3:0]        strb_q, strb_d, strb_merged;
  logic              error_q, error_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [3:0]        wr_strb_q, wr_strb_d;

  logic       accept;
  logic       last_byte;
  logic       too_long;
  logic       start_take;
  logic       busy_w;
  logic [1:0] lane;

  assign start_take = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept     = (state_q == S_RECV) && bus.in_valid;
  assign lane       = byte_cnt_q[1:0];
  assign last_byte  = (byte_cnt_q == len_q - LEN_W'(1));
  assign too_long   = {{(33 - LEN_W){1'b0}}, len_q} > CAP_BYTES;

  // Merge the incoming byte into its lane; the merged view feeds both the
  // pack register and the word handed to the write port.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic hit;
    assign hit              = accept && (lane == 2'(gi));
    assign pack_merged[gi]  = hit ? bus.in_data : pack_q[gi];
    assign strb_merged[gi]  = strb_q[gi] | hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    pack_d     = pack_q;
    strb_d     = strb_q;
    error_d    = error_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_take) begin
          state_d    = S_CHECK;
          len_d      = bus.length;
          byte_cnt_d = '0;
          word_idx_d = '0;
          pack_d     = '0;
          strb_d     = '0;
          error_d    = 1'b0;
        end
      end
      S_CHECK: begin
        if (len_q == '0) begin
          state_d = S_DONE;
        end else if (too_long) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else begin
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + LEN_W'(1);
          if ((lane == 2'd3) || last_byte) begin
            // The write port registers hold the word, so packing can restart now.
            state_d   = S_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = BASE_ADDR + (32'(word_idx_q) << 2);
            wr_data_d = pack_merged;
            wr_strb_d = strb_merged;
            pack_d    = '0;
            strb_d    = '0;
          end else begin
            pack_d = pack_merged;
            strb_d = strb_merged;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + WIDX_W'(1);
        state_d    = (byte_cnt_q == len_q) ? S_DONE : S_RECV;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      pack_q     <= '0;
      strb_q     <= '0;
      error_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE_ADDR;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
    end else begin
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      pack_q     <= pack_d;
      strb_q     <= strb_d;
      error_q    <= error_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
    end
  end

  assign busy_w       = (state_q == S_CHECK) || (state_q == S_RECV) || (state_q == S_WRITE);
  assign bus.in_ready = (state_q == S_RECV);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_strb  = wr_strb_q;
  assign bus.busy     = busy_w;
  assign bus.cpu_hold = busy_w;
  assign bus.done     = (state_q == S_DONE);
  assign bus.error    = error_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_take) begin
      csum_d = '0;
    end else if (accept) begin
      csum_d = csum_q + bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign bus.checksum = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of directed loads, hand-written reset-abort sequence and
// randomized loads, all checked against a byte-list model of the expected word writes.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int          LEN_W = 16;
  localparam int          DEPTH = 25;
  localparam logic [31:0] BASE  = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    int          len;
    int          gap;
    bit          fixed;
    logic [63:0] img;
    bit          exp_err;
    int          exp_nw;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_last_data;
    logic [3:0]  exp_last_strb;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.LEN_W(LEN_W)) bus_if ();

  imem_loader #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int         errors = 0;
  int         checks = 0;
  wr_t        got_q[$];
  wr_t        exp_q[$];
  bit         ready_seen;
  logic [7:0] img [0:127];
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] exp_sum;
`endif

  always @(negedge clk) begin
    if (!rst && bus_if.wr_en) begin
      wr_t w;
      w.addr = bus_if.wr_addr;
      w.data = bus_if.wr_data;
      w.strb = bus_if.wr_strb;
      got_q.push_back(w);
    end
    if (bus_if.in_ready) ready_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Expected writes straight from the packing rule: byte k lands in word k/4, lane k%4.
  task automatic build_model(input int len);
    exp_q.delete();
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_sum = 8'h0;
`endif
    if (len == 0 || len > 4 * DEPTH) return;
    for (int w = 0; 4 * w < len; w++) begin
      wr_t e;
      e.addr = BASE + 32'(4 * w);
      e.data = 32'h0;
      e.strb = 4'h0;
      for (int b = 0; b < 4; b++) begin
        if (4 * w + b < len) begin
          e.data[8*b +: 8] = img[4*w+b];
          e.strb[b]        = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int k = 0; k < len; k++) exp_sum = exp_sum + img[k];
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd0);
    chk({tag, "_wr_en"},    32'(bus_if.wr_en),    32'd0);
    chk({tag, "_wr_addr"},  bus_if.wr_addr,       BASE);
    chk({tag, "_wr_data"},  bus_if.wr_data,       32'd0);
    chk({tag, "_wr_strb"},  32'(bus_if.wr_strb),  32'd0);
    chk({tag, "_busy"},     32'(bus_if.busy),     32'd0);
    chk({tag, "_done"},     32'(bus_if.done),     32'd0);
    chk({tag, "_error"},    32'(bus_if.error),    32'd0);
    chk({tag, "_cpu_hold"}, 32'(bus_if.cpu_hold), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input int g, output bit ok);
    int budget = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    while (!bus_if.in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    ok = bus_if.in_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'($urandom);
    for (int i = 0; i < g; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_load(input int len, input int gap, input bit rnd_gap, input bit exp_err);
    int budget;
    bit ok;
    got_q.delete();
    ready_seen = 1'b0;
    build_model(len);
    bus_if.length = LEN_W'(len);
    bus_if.start  = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    chk("done_clear_on_start", 32'(bus_if.done), 32'd0);
    ok = 1'b1;
    if (len == 0 || len > 4 * DEPTH) begin
      @(posedge clk); #1;
      chk("done_two_cycles", 32'(bus_if.done), 32'd1);
    end else begin
      for (int k = 0; k < len && ok; k++) begin
        int g;
        g = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
        send_byte(img[k], g, ok);
      end
    end
    budget = 0;
    while (!bus_if.done && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("done",     32'(bus_if.done),     32'd1);
    chk("busy",     32'(bus_if.busy),     32'd0);
    chk("cpu_hold", 32'(bus_if.cpu_hold), 32'd0);
    chk("error",    32'(bus_if.error),    32'(exp_err));
    chk("n_writes", 32'(got_q.size()),    32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk("wr_addr", got_q[i].addr,      exp_q[i].addr);
      chk("wr_data", got_q[i].data,      exp_q[i].data);
      chk("wr_strb", 32'(got_q[i].strb), 32'(exp_q[i].strb));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("checksum", 32'(bus_if.checksum), 32'(exp_sum));
`endif
    $display("LOAD len=%0d gap=%0d writes=%0d error=%0b errors_so_far=%0d",
             len, gap, got_q.size(), bus_if.error, errors);
  endtask

  vec_t vecs[8];

  initial begin
    bit ok;
    vecs[0] = '{8,   0, 1'b1, 64'h6f10059300700513, 1'b0, 2,  32'h4,  32'h6f100593, 4'hF};
    vecs[1] = '{5,   0, 1'b1, 64'h0000006700700513, 1'b0, 2,  32'h4,  32'h00000067, 4'h1};
    vecs[2] = '{8,   3, 1'b1, 64'h6f10059300700513, 1'b0, 2,  32'h4,  32'h6f100593, 4'hF};
    vecs[3] = '{0,   0, 1'b0, 64'h0,                1'b0, 0,  32'h0,  32'h0,        4'h0};
    vecs[4] = '{101, 0, 1'b0, 64'h0,                1'b1, 0,  32'h0,  32'h0,        4'h0};
    vecs[5] = '{100, 0, 1'b0, 64'h0,                1'b0, 25, 32'h60, 32'h0,        4'hF};
    vecs[6] = '{1,   2, 1'b1, 64'h00000000000000ab, 1'b0, 1,  32'h0,  32'h000000ab, 4'h1};
    vecs[7] = '{7,   1, 1'b1, 64'h00c0ffee12345678, 1'b0, 2,  32'h4,  32'h00c0ffee, 4'h7};

    bus_if.start    = 1'b0;
    bus_if.length   = '0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      for (int k = 0; k < 128; k++) img[k] = 8'($urandom);
      if (vecs[v].fixed) for (int k = 0; k < 8; k++) img[k] = vecs[v].img[8*k +: 8];
      run_load(vecs[v].len, vecs[v].gap, 1'b0, vecs[v].exp_err);
      chk("vec_n_writes", 32'(got_q.size()), 32'(vecs[v].exp_nw));
      if (vecs[v].exp_nw > 0 && got_q.size() > 0) begin
        chk("vec_last_addr", got_q[got_q.size()-1].addr, vecs[v].exp_last_addr);
        chk("vec_last_strb", 32'(got_q[got_q.size()-1].strb), 32'(vecs[v].exp_last_strb));
        if (vecs[v].fixed) chk("vec_last_data", got_q[got_q.size()-1].data, vecs[v].exp_last_data);
      end
      if (vecs[v].exp_err) chk("err_no_ready", 32'(ready_seen), 32'd0);
    end

    // Reset abort after 6 of 8 bytes: only the first word may have been written.
    for (int k = 0; k < 8; k++) img[k] = vecs[0].img[8*k +: 8];
    got_q.delete();
    bus_if.length = LEN_W'(8);
    bus_if.start  = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 6 && ok; k++) send_byte(img[k], 0, ok);
    rst = 1'b1;
    #2;
    check_reset_vals("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_n_writes", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      chk("abort_addr", got_q[0].addr, BASE);
      chk("abort_data", got_q[0].data, 32'h00700513);
    end
    $display("ABORT writes=%0d errors_so_far=%0d", got_q.size(), errors);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) img[k] = 8'($urandom);
    run_load(4, 1, 1'b1, 1'b0);

    for (int r = 0; r < 15; r++) begin
      int len;
      len = int'($urandom_range(104, 0));
      for (int k = 0; k < 128; k++) img[k] = 8'($urandom);
      run_load(len, 2, 1'b1, len > 4 * DEPTH);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
